dx_pipeline_ctrl: RTL

Pipeline sequencing controller for the decode/execute (D/X) pipeline register of the single-cycle-derived MIPS pipeline. It produces `enable` and bubble/flush controls for the PC, F/D and D/X registers. It handles four cases: load-use hazards, taken branches/jumps resolved in X, multi-cycle mul/div occupancy of X, and memory wait states in M. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/dx_pipeline_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dx_pipeline_ctrl.sv
// D/X pipeline sequencing controller: load-use bubbles, branch redirects,
// mul/div occupancy of X, memory wait states, plus a saturating stall counter.
module dx_pipeline_ctrl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = $clog2(MULDIV_CYCLES + 1)
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        d_valid,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_uses_rs,
    input  logic        d_uses_rt,
    input  logic        d_is_muldiv,
    input  logic        x_valid,
    input  logic        x_mem_read,
    input  logic [4:0]  x_rd,
    input  logic        x_br_taken,
    input  logic        m_mem_req,
    input  logic        mem_ready,
    input  logic        stat_clear,
    output logic        pc_enable,
    output logic        fd_enable,
    output logic        flush_fd,
    output logic        dx_enable,
    output logic        dx_bubble,
    output logic        busy,
    output logic [15:0] stall_count
);

    // state       | meaning
    // ST_RUN      | normal issue; hazards resolved by priority
    // ST_MULDIV   | X occupied by mul/div, pipeline frozen for mdcnt+1 cycles
    // ST_MEM_WAIT | M access outstanding, frozen until mem_ready
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MULDIV   = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   mdcnt_q, mdcnt_d;
    logic [15:0]        stall_count_q, stall_count_d;

    logic load_use;
    logic mem_freeze;
    logic pc_en, fd_en, dx_en, flush, bubble;

    assign load_use = x_valid && x_mem_read && (x_rd != 5'd0) && d_valid &&
                      ((d_uses_rs && (d_rs == x_rd)) || (d_uses_rt && (d_rt == x_rd)));

    // In MEM_WAIT only mem_ready matters; from RUN a new unready request freezes.
    assign mem_freeze = (state_q == ST_MEM_WAIT) ? !mem_ready : (m_mem_req && !mem_ready);

    always_comb begin
        state_d = state_q;
        mdcnt_d = mdcnt_q;
        pc_en   = 1'b1;
        fd_en   = 1'b1;
        dx_en   = 1'b1;
        flush   = 1'b0;
        bubble  = 1'b0;
        if (state_q == ST_MULDIV) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            dx_en = 1'b0;
            if (mdcnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                mdcnt_d = mdcnt_q - CNT_W'(1);
            end
        end else if (mem_freeze) begin
            pc_en   = 1'b0;
            fd_en   = 1'b0;
            dx_en   = 1'b0;
            state_d = ST_MEM_WAIT;
        end else begin
            state_d = ST_RUN;
            if (x_br_taken) begin
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (load_use) begin
                pc_en  = 1'b0;
                fd_en  = 1'b0;
                bubble = 1'b1;
            end else if (d_valid && d_is_muldiv) begin
                mdcnt_d = CNT_W'(MULDIV_CYCLES - 1);
                state_d = ST_MULDIV;
            end
        end
    end

    // While reset is held the pipeline registers see a safe, flushed, frozen view.
    always_comb begin
        pc_enable = reset_n && pc_en;
        fd_enable = reset_n && fd_en;
        dx_enable = reset_n && dx_en;
        flush_fd  = !reset_n || flush;
        dx_bubble = !reset_n || bubble;
        busy      = reset_n && ((state_q == ST_MULDIV) || (state_q == ST_MEM_WAIT));
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stat_clear) begin
            stall_count_d = 16'd0;
        end else if (!pc_enable && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            mdcnt_q       <= '0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            mdcnt_q       <= mdcnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule
